// File: rtl/sm_cfg_pkg.sv
// Shared types and helpers for the switch-matrix config loader.
// Holds the loader state encoding, the CRC-16-CCITT constants and the
// word-count helper used to size the load.
package sm_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Number of config words needed to cover the chain (ceiling division).
   function automatic int nwords(input int n_bits, input int word_w);
      return (n_bits + word_w - 1) / word_w;
   endfunction

   // One MSB-first CRC-16-CCITT step for a single serial bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/sm_cfg_crc16.sv
// Bit-serial CRC-16-CCITT accumulator over the bits fed into the config chain.
// clr_i reloads the init value, en_i folds in din_i on that edge.
module sm_cfg_crc16
   import sm_cfg_pkg::*;
(
   input  logic        CLK,
   input  logic        resetn,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;

   // CRC register: clear wins over a shift step.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         crc_q <= CRC_INIT;
      end else if (clr_i) begin
         crc_q <= CRC_INIT;
      end else if (en_i) begin
         crc_q <= crc16_step(crc_q, din_i);
      end else begin
         crc_q <= crc_q;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/switch_matrix_config_loader.sv
// Switch-matrix config loader: accepts config words on a valid/ready stream,
// shifts them MSB-first into the tile's config chain, then strobes the chain
// latch so every mux select changes together.
// Optional feature macro: CONFIG_LOADER_CRC_EN adds a CRC-16 trailer check
// (trailer words accepted but not shifted; mismatch aborts with err).
module switch_matrix_config_loader
   import sm_cfg_pkg::*;
#(
   parameter int NoConfigBits = 64,
   parameter int WORD_W       = 8
) (
   input  logic              CLK,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              cfg_data,
   output logic              cfg_shift_en,
   output logic              cfg_latch,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int NWORDS = nwords(NoConfigBits, WORD_W);
`ifdef CONFIG_LOADER_CRC_EN
   localparam int CRC_WORDS = 16 / WORD_W;
`else
   localparam int CRC_WORDS = 0;
`endif
   localparam int TOTAL_WORDS = NWORDS + CRC_WORDS;
   localparam int WCNT_W = $clog2(TOTAL_WORDS + 3);
   localparam int BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [WCNT_W-1:0] TOTAL_C  = WCNT_W'(TOTAL_WORDS);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d, word_shift_s;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic                err_q, err_d;
   logic                cfg_data_q, cfg_data_d;
   logic                word_ready_q, cfg_shift_en_q, cfg_latch_q, busy_q, done_q;

   assign word_shift_s = word_q << 1;

`ifdef CONFIG_LOADER_CRC_EN
   localparam logic [WCNT_W-1:0] NWORDS_C = WCNT_W'(NWORDS);
   logic [15:0] crc_s, crc_rx_q, crc_rx_d, crc_rx_next_s;
   logic        crc_clr_s;

   if ((16 % WORD_W) != 0) begin : g_word_w_check
      $error("WORD_W must divide 16 when CONFIG_LOADER_CRC_EN is defined");
   end

   // Received trailer assembled high word first; compared as the last word arrives.
   assign crc_rx_next_s = 16'(crc_rx_q << WORD_W) | 16'(word_data);

   sm_cfg_crc16 u_crc (
      .CLK    (CLK),
      .resetn (resetn),
      .clr_i  (crc_clr_s),
      .en_i   (cfg_shift_en_q),
      .din_i  (cfg_data_q),
      .crc_o  (crc_s)
   );
`endif

   // Next-state logic; abort in any busy state overrides every other event.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      wcnt_d     = wcnt_q;
      bcnt_d     = bcnt_q;
      err_d      = err_q;
      cfg_data_d = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
      crc_rx_d   = crc_rx_q;
      crc_clr_s  = 1'b0;
`endif
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         err_d   = 1'b1;
         word_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  err_d  = 1'b0;
                  wcnt_d = '0;
                  bcnt_d = '0;
`ifdef CONFIG_LOADER_CRC_EN
                  crc_clr_s = 1'b1;
                  crc_rx_d  = '0;
`endif
                  // A hard-wired matrix has nothing to load: report completion at once.
                  state_d = (NWORDS == 0) ? DONE : LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD: begin
               if (word_valid) begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
`ifdef CONFIG_LOADER_CRC_EN
                  if (wcnt_q >= NWORDS_C) begin
                     crc_rx_d = crc_rx_next_s;
                     if (wcnt_d == TOTAL_C) begin
                        if (crc_rx_next_s == crc_s) begin
                           state_d = LATCH;
                        end else begin
                           state_d = IDLE;
                           err_d   = 1'b1;
                        end
                     end else begin
                        state_d = LOAD;
                     end
                  end else begin
                     word_d     = word_data;
                     bcnt_d     = '0;
                     cfg_data_d = word_data[WORD_W-1];
                     state_d    = SHIFT;
                  end
`else
                  word_d     = word_data;
                  bcnt_d     = '0;
                  cfg_data_d = word_data[WORD_W-1];
                  state_d    = SHIFT;
`endif
               end else begin
                  state_d = LOAD;
               end
            end
            SHIFT: begin
               word_d = word_shift_s;
               if (bcnt_q == LAST_BIT) begin
                  bcnt_d  = '0;
                  state_d = (wcnt_q < TOTAL_C) ? LOAD : LATCH;
               end else begin
                  bcnt_d     = bcnt_q + BCNT_W'(1);
                  cfg_data_d = word_shift_s[WORD_W-1];
                  state_d    = SHIFT;
               end
            end
            LATCH: begin
               state_d = DONE;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q        <= IDLE;
         word_q         <= '0;
         wcnt_q         <= '0;
         bcnt_q         <= '0;
         err_q          <= 1'b0;
         cfg_data_q     <= 1'b0;
         word_ready_q   <= 1'b0;
         cfg_shift_en_q <= 1'b0;
         cfg_latch_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
         crc_rx_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         word_q         <= word_d;
         wcnt_q         <= wcnt_d;
         bcnt_q         <= bcnt_d;
         err_q          <= err_d;
         cfg_data_q     <= cfg_data_d;
         word_ready_q   <= (state_d == LOAD);
         cfg_shift_en_q <= (state_d == SHIFT);
         cfg_latch_q    <= (state_d == LATCH);
         busy_q         <= (state_d != IDLE);
         done_q         <= (state_d == DONE);
`ifdef CONFIG_LOADER_CRC_EN
         crc_rx_q       <= crc_rx_d;
`endif
      end
   end

   assign word_ready   = word_ready_q;
   assign cfg_data     = cfg_data_q;
   assign cfg_shift_en = cfg_shift_en_q;
   assign cfg_latch    = cfg_latch_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_switch_matrix_config_loader.sv
// Self-checking bench for switch_matrix_config_loader: a queue-based model of
// the load sequence is checked every cycle, plus directed scenarios with
// hand-computed expectations and a hard-wired (NoConfigBits=0) instance.
module tb_switch_matrix_config_loader;

   localparam int NB = 20;
   localparam int W  = 8;
   localparam int NW = (NB + W - 1) / W;
`ifdef CONFIG_LOADER_CRC_EN
   localparam int CRCW = 16 / W;
`else
   localparam int CRCW = 0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start = 1'b0, abort = 1'b0, word_valid = 1'b0;
   logic [W-1:0] word_data = '0;
   logic word_ready, cfg_data, cfg_shift_en, cfg_latch, busy, done, err;

   logic z_start = 1'b0;
   logic z_word_ready, z_cfg_data, z_cfg_shift_en, z_cfg_latch, z_busy, z_done, z_err;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   switch_matrix_config_loader #(.NoConfigBits(NB), .WORD_W(W)) dut (
      .CLK(clk), .resetn(resetn), .start(start), .abort(abort),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .cfg_data(cfg_data), .cfg_shift_en(cfg_shift_en), .cfg_latch(cfg_latch),
      .busy(busy), .done(done), .err(err));

   switch_matrix_config_loader #(.NoConfigBits(0), .WORD_W(W)) dut_z (
      .CLK(clk), .resetn(resetn), .start(z_start), .abort(1'b0),
      .word_data(8'h5A), .word_valid(1'b1), .word_ready(z_word_ready),
      .cfg_data(z_cfg_data), .cfg_shift_en(z_cfg_shift_en), .cfg_latch(z_cfg_latch),
      .busy(z_busy), .done(z_done), .err(z_err));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- emulated tile chain and event counters ----------------
   logic [NB-1:0] chain_q = '0, act_chain = '0;
   logic [31:0]   cap = '0;
   int n_shift = 0, n_latch = 0, n_done = 0, cyc = 0, latch_cyc = 0, done_cyc = 0;
   int z_bad = 0, z_dones = 0;

   always @(posedge clk) begin
      cyc++;
      if (cfg_shift_en) begin
         chain_q = {chain_q[NB-2:0], cfg_data};
         cap     = {cap[30:0], cfg_data};
         n_shift++;
      end
      if (cfg_latch) begin
         act_chain = chain_q;
         n_latch++;
         latch_cyc = cyc;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (z_word_ready || z_cfg_shift_en || z_cfg_latch) z_bad++;
      if (z_done) z_dones++;
   end

   // ---------------- behavioural model (queues of pending bits) ----------------
   bit m_active = 0, m_latch_due = 0, m_done_due = 0, m_err = 0;
   bit m_bits[$];
   bit m_stream[$];
   int m_words = 0;
   logic [15:0] m_crc_rx = '0;
   logic [NB-1:0] m_exp_chain = '0;

`ifdef CONFIG_LOADER_CRC_EN
   function automatic logic [15:0] crc_bits(input bit q[$]);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (q[i]) begin
         if (c[15] ^ q[i]) c = (c << 1) ^ 16'h1021;
         else c = c << 1;
      end
      return c;
   endfunction
`endif

   always @(posedge clk) begin
      if (!resetn) begin
         m_active = 0; m_latch_due = 0; m_done_due = 0; m_err = 0;
         m_bits.delete();
      end else if (abort && m_active) begin
         m_active = 0; m_latch_due = 0; m_done_due = 0; m_err = 1;
         m_bits.delete();
      end else if (!m_active) begin
         if (start) begin
            m_active = 1; m_err = 0; m_words = 0; m_crc_rx = '0;
            m_stream.delete();
            if (NW == 0) m_done_due = 1;
         end
      end else if (m_done_due) begin
         m_done_due = 0; m_active = 0;
      end else if (m_latch_due) begin
         m_latch_due = 0; m_done_due = 1;
         for (int i = 0; i < NB; i++) m_exp_chain[i] = m_stream[m_stream.size() - 1 - i];
      end else if (m_bits.size() > 0) begin
         m_stream.push_back(m_bits.pop_front());
         if (m_bits.size() == 0 && m_words == NW + CRCW) m_latch_due = 1;
      end else if (word_valid) begin
         m_words++;
         if (m_words <= NW) begin
            for (int i = W - 1; i >= 0; i--) m_bits.push_back(word_data[i]);
         end else begin
`ifdef CONFIG_LOADER_CRC_EN
            m_crc_rx = 16'(m_crc_rx << W) | 16'(word_data);
            if (m_words == NW + CRCW) begin
               if (m_crc_rx == crc_bits(m_stream)) m_latch_due = 1;
               else begin m_active = 0; m_err = 1; end
            end
`endif
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   logic e_ready, e_shift, e_data, e_latch, e_busy, e_done, e_err;
   always @(negedge clk) begin
      if (!resetn) begin
         {e_ready, e_shift, e_data, e_latch, e_busy, e_done, e_err} = 7'b0;
      end else begin
         e_ready = m_active && !m_done_due && !m_latch_due && (m_bits.size() == 0);
         e_shift = (m_bits.size() > 0);
         e_data  = e_shift ? m_bits[0] : 1'b0;
         e_latch = m_latch_due;
         e_busy  = m_active;
         e_done  = m_done_due;
         e_err   = m_err;
      end
      chk("word_ready", word_ready, e_ready);
      chk("cfg_shift_en", cfg_shift_en, e_shift);
      chk("cfg_data", cfg_data, e_data);
      chk("cfg_latch", cfg_latch, e_latch);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      if (resetn && m_done_due) chk("latched_chain", act_chain, m_exp_chain);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input int gap);
      int k = 0;
      while (!word_ready && k < 64) begin tick(); k++; end
      chk("ready_wait", word_ready, 1'b1);
      repeat (gap) begin
         chk("gap_ready_high", word_ready, 1'b1);
         chk("gap_no_shift", cfg_shift_en, 1'b0);
         tick();
      end
      word_valid = 1'b1;
      word_data  = w;
      tick();
      word_valid = 1'b0;
      word_data  = '0;
   endtask

   // Three data words plus, when the CRC trailer is built in, its trailer words.
   task automatic load_words(input logic [23:0] d, input int gap, input bit flip);
      send_word(d[23:16], gap);
      send_word(d[15:8], gap);
      send_word(d[7:0], gap);
`ifdef CONFIG_LOADER_CRC_EN
      begin
         bit q[$];
         logic [15:0] c;
         for (int i = 23; i >= 0; i--) q.push_back(d[i]);
         c = crc_bits(q) ^ {15'b0, flip};
         for (int i = 0; i < CRCW; i++) send_word(c[15 - i*W -: W], 0);
      end
`else
      if (flip) $display("note: trailer corruption has no effect without the CRC trailer");
`endif
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (!done && k < 64) begin tick(); k++; end
      chk(name, done, 1'b1);
      tick();
   endtask

   int s0, l0, d0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(); tick();
      chk("reset_outputs", {word_ready, cfg_data, cfg_shift_en, cfg_latch, busy, done, err}, 7'b0);
      resetn = 1'b1;
      tick();
      chk("post_reset_idle", {busy, err, word_ready}, 3'b000);

      // Test 1: A5,3C,0F streamed back to back
      s0 = n_shift; l0 = n_latch; d0 = n_done;
      start_load();
      load_words(24'hA53C0F, 0, 1'b0);
      wait_done("t1_done_seen");
      chk("t1_shift_count", n_shift - s0, 24);
      chk("t1_bit_sequence", cap[23:0], 24'hA53C0F);
      chk("t1_chain", act_chain, 20'h53C0F);
      chk("t1_latch_count", n_latch - l0, 1);
      chk("t1_done_lag", done_cyc - latch_cyc, 1);
      chk("t1_done_count", n_done - d0, 1);
      tick();

      // Test 2: 5-cycle gaps on word_valid
      s0 = n_shift; l0 = n_latch;
      act_chain = '0;
      start_load();
      load_words(24'hA53C0F, 5, 1'b0);
      wait_done("t2_done_seen");
      chk("t2_shift_count", n_shift - s0, 24);
      chk("t2_chain", act_chain, 20'h53C0F);
      chk("t2_latch_count", n_latch - l0, 1);
      tick();

      // Test 3: abort in the 3rd SHIFT cycle of word 2
      l0 = n_latch; d0 = n_done;
      start_load();
      send_word(8'hA5, 0);
      send_word(8'h3C, 0);
      tick(); tick();
      chk("t3_in_shift", cfg_shift_en, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t3_idle_after_abort", {busy, err, word_ready}, 3'b010);
      repeat (4) tick();
      chk("t3_no_latch", n_latch - l0, 0);
      chk("t3_no_done", n_done - d0, 0);
      start_load();
      chk("t3_err_cleared", {busy, err}, 2'b10);
      load_words(24'h0F3CA5, 0, 1'b0);
      wait_done("t3_reload_done");
      chk("t3_reload_chain", act_chain, 20'hCA5 | 20'hF3000);
      tick();

      // Test 4: async reset during SHIFT
      l0 = n_latch;
      start_load();
      send_word(8'hA5, 0);
      send_word(8'h3C, 0);
      tick();
      #2 resetn = 1'b0;
      #1 chk("t4_async_clear", {word_ready, cfg_data, cfg_shift_en, cfg_latch, busy, done, err}, 7'b0);
      tick(); tick();
      resetn = 1'b1;
      tick();
      chk("t4_no_latch", n_latch - l0, 0);
      start_load();
      load_words(24'hA53C0F, 0, 1'b0);
      wait_done("t4_done_after_reset");
      chk("t4_chain", act_chain, 20'h53C0F);
      tick();

      // Test 5: hard-wired matrix (NoConfigBits=0)
      z_start = 1'b1;
      tick();
      z_start = 1'b0;
      chk("t5_done_next_cycle", {z_done, z_busy}, 2'b11);
      tick();
      chk("t5_done_single", {z_done, z_busy}, 2'b00);
      chk("t5_done_pulses", z_dones, 1);

`ifdef CONFIG_LOADER_CRC_EN
      // Test 6: CRC trailer correct, then corrupted
      l0 = n_latch;
      start_load();
      load_words(24'hA53C0F, 0, 1'b0);
      wait_done("t6_good_crc_done");
      chk("t6_good_latch", n_latch - l0, 1);
      tick();
      l0 = n_latch; d0 = n_done;
      start_load();
      load_words(24'hA53C0F, 0, 1'b1);
      chk("t6_bad_crc_err", {busy, err}, 2'b01);
      repeat (4) tick();
      chk("t6_bad_no_latch", n_latch - l0, 0);
      chk("t6_bad_no_done", n_done - d0, 0);
`endif

      // Randomised traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         start      = ($urandom_range(0, 9) == 0);
         abort      = ($urandom_range(0, 79) == 0);
         word_valid = ($urandom_range(0, 2) != 0);
         word_data  = W'($urandom);
         tick();
      end
      start = 1'b0; word_valid = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("rand_end_idle", busy, 1'b0);
      chk("z_never_loads", z_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
